fifo_wide_rd: RTL and testbench



---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_wide_rd_ctrl.sv | 75 +++++++
 rtl/fifo_wide_rd.sv | 60 ++++++
 tb/tb_fifo_wide_rd.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and geometry helper for the width-doubling read FIFO.
// No state and no flow control; constants only.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_wide_rd_ctrl.sv
// Pointer/occupancy controller: one-word pushes, two-word pops, status decode.
// Status is a combinational decode of count; full refuses writes, fewer than two words refuses reads.
module fifo_wide_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr0,
    output logic [ADDR_WIDTH-1:0] r_addr1,
    output logic                  pair_vld,
    output logic                  empty,
    output logic                  one_left,
    output logic                  full
);

    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_TWO   = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(depth_of(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    // With ADDR_WIDTH=1 this truncates to 0, which is exactly the mod-2 step.
    localparam logic [ADDR_WIDTH-1:0] PTR_TWO   = ADDR_WIDTH'(2);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  wr_acc;
    logic                  rd_acc;

    always_comb begin
        empty    = (count_q == '0);
        one_left = (count_q == CNT_ONE);
        full     = (count_q == CNT_DEPTH);
        pair_vld = (count_q >= CNT_TWO);

        // Both requests are judged against the pre-edge occupancy.
        wr_acc   = wr & ~full;
        rd_acc   = rd & pair_vld;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_d + CNT_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_TWO;
            count_d  = count_d - CNT_TWO;
        end

        w_en    = wr_acc;
        w_addr  = wr_ptr_q;
        r_addr0 = rd_ptr_q;
        r_addr1 = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fifo_wide_rd.sv
// Width-doubling FIFO: narrow word in, {older, newer} pair out; fall-through read, 1-cycle write-to-read.
// Writes dropped when full, reads dropped with fewer than two words stored; no error indication.
module fifo_wide_rd
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic                    rd,
    output logic [2*DATA_WIDTH-1:0] r_data,
    output logic                    empty,
    output logic                    one_left,
    output logic                    full
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  w_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [ADDR_WIDTH-1:0] r_addr1;
    logic                  pair_vld;

    fifo_wide_rd_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .rd       (rd),
        .w_en     (w_en),
        .w_addr   (w_addr),
        .r_addr0  (r_addr0),
        .r_addr1  (r_addr1),
        .pair_vld (pair_vld),
        .empty    (empty),
        .one_left (one_left),
        .full     (full)
    );

    // Storage is deliberately unreset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_en && reset) begin
            mem[w_addr] <= w_data;
        end
    end

    always_comb begin
        r_data = '0;
        if (pair_vld) begin
            r_data = {mem[r_addr0], mem[r_addr1]};
        end
    end

endmodule

// File: tb/tb_fifo_wide_rd.sv
// Directed bench for fifo_wide_rd at DATA_WIDTH=8, ADDR_WIDTH=2 (four-word storage).
// Each scenario task drives one cycle at a time and checks status and pair output between edges.
module tb_fifo_wide_rd;

    logic        clk;
    logic        reset;
    logic        wr;
    logic [7:0]  w_data;
    logic        rd;
    logic [15:0] r_data;
    logic        empty;
    logic        one_left;
    logic        full;

    int total;
    int bad;

    fifo_wide_rd #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .w_data   (w_data),
        .rd       (rd),
        .r_data   (r_data),
        .empty    (empty),
        .one_left (one_left),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given requests, then release them just after the edge.
    task automatic step(input logic do_wr, input logic [7:0] d, input logic do_rd);
        wr     = do_wr;
        w_data = d;
        rd     = do_rd;
        @(posedge clk);
        #1;
        wr     = 1'b0;
        rd     = 1'b0;
        w_data = 8'h00;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        wr     = 1'b0;
        rd     = 1'b0;
        w_data = 8'h00;
        #2;
        reset  = 1'b0;
        #1;
        total++;
        if ({empty, one_left, full, r_data} !== {3'b100, 16'h0000}) begin
            bad++;
            $display("FAIL reset_async got e/o/f=%b%b%b r=%h exp 100 r=0000", empty, one_left, full, r_data);
        end
        wr     = 1'b1;
        w_data = 8'h5A;
        @(posedge clk);
        @(posedge clk);
        #1;
        total++;
        if ({empty, one_left, full, r_data} !== {3'b100, 16'h0000}) begin
            bad++;
            $display("FAIL reset_hold_ignores_wr got e/o/f=%b%b%b r=%h exp 100 r=0000", empty, one_left, full, r_data);
        end
        wr    = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_single_word();
        step(1'b1, 8'hA1, 1'b0);
        total++;
        if ({empty, one_left, full, r_data} !== {3'b010, 16'h0000}) begin
            bad++;
            $display("FAIL one_word got e/o/f=%b%b%b r=%h exp 010 r=0000", empty, one_left, full, r_data);
        end
        step(1'b0, 8'h00, 1'b1);
        total++;
        if ({empty, one_left, full, r_data} !== {3'b010, 16'h0000}) begin
            bad++;
            $display("FAIL rd_refused_one got e/o/f=%b%b%b r=%h exp 010 r=0000", empty, one_left, full, r_data);
        end
        step(1'b1, 8'hB2, 1'b0);
        total++;
        if ({empty, one_left, full, r_data} !== {3'b000, 16'hA1B2}) begin
            bad++;
            $display("FAIL first_pair got e/o/f=%b%b%b r=%h exp 000 r=a1b2", empty, one_left, full, r_data);
        end
        step(1'b0, 8'h00, 1'b1);
        total++;
        if ({empty, one_left, full, r_data} !== {3'b100, 16'h0000}) begin
            bad++;
            $display("FAIL pop_to_empty got e/o/f=%b%b%b r=%h exp 100 r=0000", empty, one_left, full, r_data);
        end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 8'(i), 1'b0);
        end
        total++;
        if ({empty, one_left, full, r_data} !== {3'b001, 16'h0102}) begin
            bad++;
            $display("FAIL fill got e/o/f=%b%b%b r=%h exp 001 r=0102", empty, one_left, full, r_data);
        end
        step(1'b1, 8'h05, 1'b0);
        total++;
        if ({empty, one_left, full, r_data} !== {3'b001, 16'h0102}) begin
            bad++;
            $display("FAIL wr_when_full got e/o/f=%b%b%b r=%h exp 001 r=0102", empty, one_left, full, r_data);
        end
        step(1'b0, 8'h00, 1'b1);
        total++;
        if ({empty, one_left, full, r_data} !== {3'b000, 16'h0304}) begin
            bad++;
            $display("FAIL second_pair got e/o/f=%b%b%b r=%h exp 000 r=0304", empty, one_left, full, r_data);
        end
        step(1'b0, 8'h00, 1'b1);
        total++;
        if ({empty, one_left, full, r_data} !== {3'b100, 16'h0000}) begin
            bad++;
            $display("FAIL drain got e/o/f=%b%b%b r=%h exp 100 r=0000", empty, one_left, full, r_data);
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        total++;
        if ({empty, one_left, full, r_data} !== {3'b000, 16'h1122}) begin
            bad++;
            $display("FAIL wrap_head got e/o/f=%b%b%b r=%h exp 000 r=1122", empty, one_left, full, r_data);
        end
        step(1'b0, 8'h00, 1'b1);
        total++;
        if ({empty, one_left, full, r_data} !== {3'b010, 16'h0000}) begin
            bad++;
            $display("FAIL wrap_pop got e/o/f=%b%b%b r=%h exp 010 r=0000", empty, one_left, full, r_data);
        end
        step(1'b1, 8'h44, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h66, 1'b0);
        total++;
        if ({empty, one_left, full, r_data} !== {3'b001, 16'h3344}) begin
            bad++;
            $display("FAIL wrap_full got e/o/f=%b%b%b r=%h exp 001 r=3344", empty, one_left, full, r_data);
        end
        step(1'b0, 8'h00, 1'b1);
        total++;
        if ({empty, one_left, full, r_data} !== {3'b000, 16'h5566}) begin
            bad++;
            $display("FAIL wrap_tail got e/o/f=%b%b%b r=%h exp 000 r=5566", empty, one_left, full, r_data);
        end
        step(1'b0, 8'h00, 1'b1);
        total++;
        if ({empty, one_left, full, r_data} !== {3'b100, 16'h0000}) begin
            bad++;
            $display("FAIL wrap_drain got e/o/f=%b%b%b r=%h exp 100 r=0000", empty, one_left, full, r_data);
        end
    endtask

    task automatic test_simultaneous();
        step(1'b1, 8'hC1, 1'b0);
        step(1'b1, 8'hC2, 1'b0);
        step(1'b1, 8'hC3, 1'b0);
        step(1'b1, 8'hC4, 1'b0);
        step(1'b1, 8'hD5, 1'b1);
        total++;
        if ({empty, one_left, full, r_data} !== {3'b000, 16'hC3C4}) begin
            bad++;
            $display("FAIL rdwr_full got e/o/f=%b%b%b r=%h exp 000 r=c3c4", empty, one_left, full, r_data);
        end
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hE1, 1'b0);
        step(1'b1, 8'hE2, 1'b1);
        total++;
        if ({empty, one_left, full, r_data} !== {3'b000, 16'hE1E2}) begin
            bad++;
            $display("FAIL rdwr_one_left got e/o/f=%b%b%b r=%h exp 000 r=e1e2", empty, one_left, full, r_data);
        end
        step(1'b0, 8'h00, 1'b1);
        total++;
        if ({empty, one_left, full, r_data} !== {3'b100, 16'h0000}) begin
            bad++;
            $display("FAIL rdwr_drain got e/o/f=%b%b%b r=%h exp 100 r=0000", empty, one_left, full, r_data);
        end
    endtask

    task automatic test_reset_midop();
        step(1'b1, 8'hF1, 1'b0);
        step(1'b1, 8'hF2, 1'b0);
        step(1'b1, 8'hF3, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({empty, one_left, full, r_data} !== {3'b100, 16'h0000}) begin
            bad++;
            $display("FAIL midop_reset got e/o/f=%b%b%b r=%h exp 100 r=0000", empty, one_left, full, r_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b1, 8'hAA, 1'b0);
        total++;
        if ({empty, one_left, full, r_data} !== {3'b010, 16'h0000}) begin
            bad++;
            $display("FAIL post_reset_one got e/o/f=%b%b%b r=%h exp 010 r=0000", empty, one_left, full, r_data);
        end
        step(1'b1, 8'hBB, 1'b0);
        total++;
        if ({empty, one_left, full, r_data} !== {3'b000, 16'hAABB}) begin
            bad++;
            $display("FAIL post_reset_pair got e/o/f=%b%b%b r=%h exp 000 r=aabb", empty, one_left, full, r_data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_word();
        test_full();
        test_wrap();
        test_simultaneous();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
